// File: rtl/pheri_sys_button_pio_if.sv
// pheri_sys_button_pio_if: Avalon-MM slave bus bundle for the button PIO.
interface pheri_sys_button_pio_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pheri_sys_button_pio.sv
// pheri_sys_button_pio: synchronized/debounced button input port with sticky edge capture and masked irq.
// Define PHERI_SYS_BUTTON_PIO_DEBOUNCE_EN to compile in the tick-sampled debounce stage.
module pheri_sys_button_pio #(
   parameter int WIDTH           = 8,
   parameter int EDGE_TYPE       = 1,
   parameter int IDLE_LEVEL      = 1,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic                 clk,
   input  logic                 reset,
   pheri_sys_button_pio_if.slave bus,
   input  logic [WIDTH-1:0]     in_port,
   output logic                 irq
);
   localparam logic [WIDTH-1:0] IDLE = {WIDTH{1'(IDLE_LEVEL)}};
   logic [WIDTH-1:0] sync1, sync2, db, db_prev, irq_mask, edge_cap, edge_det;
   logic wr;
   logic unused_wdata;
   assign unused_wdata = &{1'b0, bus.writedata};
   assign wr = bus.chipselect & ~bus.write_n;
   always_comb edge_det = EDGE_TYPE == 0 ? db & ~db_prev :
                          EDGE_TYPE == 1 ? ~db & db_prev : db ^ db_prev;
`ifdef PHERI_SYS_BUTTON_PIO_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sample, stable;
   logic             tick;
   assign tick   = cnt == CW'(DEBOUNCE_CYCLES - 1);
   assign stable = ~(sync2 ^ sample);
   // a bit only moves once two consecutive ticks agree on its new level
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         sample <= IDLE;
         db     <= IDLE;
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         if (tick) begin
            db     <= (stable & sync2) | (~stable & db);
            sample <= sync2;
         end
      end
   end
`else
   assign db = sync2;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1    <= IDLE;
         sync2    <= IDLE;
         db_prev  <= IDLE;
         irq_mask <= '0;
         edge_cap <= '0;
      end else begin
         sync1   <= in_port;
         sync2   <= sync1;
         db_prev <= db;
         if (wr && bus.address == 2'd2) irq_mask <= bus.writedata[WIDTH-1:0];
         edge_cap <= ((wr && bus.address == 2'd3) ? edge_cap & ~bus.writedata[WIDTH-1:0] : edge_cap) | edge_det;
      end
   end
   always_comb bus.readdata = bus.address == 2'd0 ? 32'(db) :
                              bus.address == 2'd2 ? 32'(irq_mask) :
                              bus.address == 2'd3 ? 32'(edge_cap) : 32'd0;
   assign irq = |(edge_cap & irq_mask);
endmodule

// File: tb/tb_pheri_sys_button_pio.sv
// tb_pheri_sys_button_pio: directed-vector bench for the button PIO (falling-edge, WIDTH=8).
module tb_pheri_sys_button_pio;
   logic       clk = 0;
   logic       reset = 1;
   logic [7:0] in_port = 8'hFF;
   logic       irq;
   int         total = 0;
   int         bad = 0;
   pheri_sys_button_pio_if bus();
   pheri_sys_button_pio #(.WIDTH(8), .EDGE_TYPE(1), .IDLE_LEVEL(1), .DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave), .in_port(in_port), .irq(irq));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus.address = a;
      bus.writedata = d;
      bus.chipselect = 1;
      bus.write_n = 0;
      @(negedge clk);
      bus.chipselect = 0;
      bus.write_n = 1;
   endtask
   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      bus.address = a;
      #1 d = bus.readdata;
   endtask
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask
   logic [31:0] r;
   initial begin
      bus.address = 0;
      bus.chipselect = 0;
      bus.write_n = 1;
      bus.writedata = 0;
      cyc(3);
      reset = 0;
      rd(0, r); chk("rst_data", r, 32'hFF);
      rd(3, r); chk("rst_edgecap", r, 0);
      rd(2, r); chk("rst_mask", r, 0);
      chk("rst_irq", 32'(irq), 0);
      cyc(10);
      rd(3, r); chk("rst_no_edge", r, 0);
`ifdef PHERI_SYS_BUTTON_PIO_DEBOUNCE_EN
      in_port = 8'hFE;
      cyc(3);
      in_port = 8'hFF;
      cyc(20);
      rd(0, r); chk("glitch_data", r, 32'hFF);
      rd(3, r); chk("glitch_edgecap", r, 0);
      in_port = 8'hFE;
      cyc(2);
      rd(0, r); chk("db_early", r, 32'hFF);
      cyc(8);
      rd(0, r); chk("db_data", r, 32'hFE);
      rd(3, r); chk("db_edgecap", r, 32'h01);
      cyc(2);
      in_port = 8'hFF;
      cyc(12);
      rd(0, r); chk("db_release", r, 32'hFF);
      rd(3, r); chk("db_release_cap", r, 32'h01);
`else
      wr(2, 32'h01);
      in_port = 8'hFE;
      cyc(2);
      rd(0, r); chk("fall_data", r, 32'hFE);
      rd(3, r); chk("fall_cap_early", r, 0);
      cyc(1);
      rd(3, r); chk("fall_cap", r, 32'h01);
      chk("fall_irq", 32'(irq), 1);
      wr(3, 32'h01);
      rd(3, r); chk("clr_cap", r, 0);
      chk("clr_irq", 32'(irq), 0);
      wr(2, 32'h00);
      in_port = 8'hF6;
      cyc(3);
      rd(3, r); chk("mask_cap", r, 32'h08);
      chk("mask_irq_off", 32'(irq), 0);
      wr(2, 32'h08);
      chk("mask_irq_on", 32'(irq), 1);
      wr(3, 32'h08);
      chk("mask_irq_clr", 32'(irq), 0);
      in_port = 8'hF2;
      cyc(2);
      wr(3, 32'h04);
      rd(3, r); chk("set_over_clear", r, 32'h04);
      wr(3, 32'h04);
      rd(3, r); chk("clear_after", r, 0);
      in_port = 8'hFF;
      cyc(4);
      rd(3, r); chk("rise_ignored", r, 0);
`endif
      wr(0, 32'hFFFF_FFFF);
      wr(1, 32'hFFFF_FFFF);
      rd(0, r); chk("dec_data", r, 32'hFF);
      rd(1, r); chk("dec_rsvd", r, 0);
      wr(2, 32'hFFFF_FFFF);
      rd(2, r); chk("dec_mask", r, 32'h0000_00FF);
      in_port = 8'h7F;
      cyc(12);
      chk("irq_bit7", 32'(irq), 1);
      reset = 1;
      cyc(2);
      reset = 0;
      rd(2, r); chk("rst2_mask", r, 0);
      rd(3, r); chk("rst2_cap", r, 0);
      chk("rst2_irq", 32'(irq), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pheri_sys_button_pio.md
# pheri_sys_button_pio

Avalon-MM slave input port that samples external buttons or switches, synchronizes and optionally debounces them, and records edges in a sticky capture register. It raises a level interrupt to the Nios II processor. It is the read-side companion to the write-only seven-segment output PIO and sits on the same peripheral interconnect, with zero-wait-state reads.

## Interface
- WIDTH, 8: number of input bits (1..32).
- EDGE_TYPE, 1: edge detected per bit; 0 = rising, 1 = falling, 2 = any.
- IDLE_LEVEL, 1: level loaded into all input-path registers at reset (buttons are active-low).
- DEBOUNCE_CYCLES, 50000: clk cycles between debounce samples (≥2). Used only when the debounce stage is compiled in.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register word select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  combinational read data.
- in_port  in  WIDTH  asynchronous external inputs.
- irq  out  1  level interrupt request.

## Operation
- Input path: in_port → 2-flop synchronizer (sync1, sync2) → debounced value `db` → previous-value register `db_prev`.
- `edge` per bit is derived from `db` and `db_prev`:
  - rising: db & ~db_prev
  - falling: ~db & db_prev
  - any: db ^ db_prev
- Register map (word addresses):
  - 0 DATA: read returns db zero-extended to 32 bits. Writes are ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 IRQMASK: R/W, WIDTH bits. Upper bits read 0.
  - 3 EDGECAP: read returns the capture bits.
    - Write clears each bit whose writedata bit is 1 (bit-clearing).
    - In the same cycle, capture |= edge.
    - If a new edge and a clear hit the same bit in the same cycle, set wins.
- A write occurs when chipselect=1 and write_n=0. Reads have no side effects.
- irq = |(EDGECAP & IRQMASK). It is combinational from registers only, so it is glitch-free.
- Reset (synchronous, takes priority over everything):
  - sync1, sync2, db, db_prev and the debounce sample register load {WIDTH{IDLE_LEVEL}}.
  - IRQMASK, EDGECAP and the tick counter load 0.
  - irq = 0. readdata follows address from the reset values.
- Reset asserted mid-debounce discards any partial sample, so no edge is generated on reset release.

## Timing
- readdata is combinational from address. Read latency is 0, with no waitrequest.
- Register writes take effect at the clock edge where chipselect & ~write_n is sampled. The new value is visible on readdata in the following cycle.
- Without debounce, a stable in_port change sampled at edge k is handled as follows:
  - db (= sync2) updates at k+1 and DATA reflects it after k+1.
  - EDGECAP sets at k+2; irq rises after k+2 if the bit is masked in.
- With debounce:
  - The tick counter runs 0..DEBOUNCE_CYCLES-1 and wraps. tick=1 when the counter equals DEBOUNCE_CYCLES-1.
  - On a tick, each db bit takes sync2 only if sync2 equals the sample register; the sample register then loads sync2.
  - A change must be stable across two consecutive ticks. Latency from sync2 change to db change is DEBOUNCE_CYCLES+1 to 2·DEBOUNCE_CYCLES cycles.
  - Glitches shorter than one tick period never reach db.
- db_prev loads db every cycle, so each db transition yields exactly a one-cycle edge pulse.
- Clearing an EDGECAP bit drops irq in the cycle after the write, unless another masked bit remains set.

## Configuration
- PHERI_SYS_BUTTON_PIO_DEBOUNCE_EN:
  - Defined: the tick counter, sample register and debounce update logic are instantiated as described above.
  - Undefined: db = sync2 directly; DEBOUNCE_CYCLES is ignored; no counter logic is synthesized.

## Test plan
- Reset: hold reset 3 cycles with in_port=8'hFF → DATA reads 8'hFF, EDGECAP reads 0, IRQMASK reads 0, irq=0; no edge captured after release.
- Falling edge, no debounce: IRQMASK=8'h01, drive in_port bit0 1→0 → EDGECAP=8'h01 two cycles later and irq=1. Write 8'h01 to EDGECAP → EDGECAP=0 and irq=0 next cycle.
- Mask gating: IRQMASK=8'h00, press bit3 → EDGECAP=8'h08 and irq stays 0. Write IRQMASK=8'h08 → irq=1 the next cycle.
- Set-over-clear: arrange an edge on bit2 to land in the same cycle as an EDGECAP write of 8'h04 → bit2 remains 1.
- Debounce (macro defined, DEBOUNCE_CYCLES=4):
  - A 3-cycle low glitch on bit0 → DATA stays 8'hFF and EDGECAP stays 0.
  - A 12-cycle-stable low → DATA bit0=0 within 8 cycles of sync2 changing, and EDGECAP bit0=1.
- Address decode: write 32'hFFFF_FFFF to addresses 0 and 1 → DATA unchanged, address 1 reads 0. Read IRQMASK after writing 32'hFFFF_FFFF → 32'h0000_00FF.
